// File: rtl/sdq_arb_pkg.sv
// sdq_arb_pkg - shared types and helpers for the sdq_arbiter slice.
//
// Contents:
//   sdq_arb_state_e : arbiter mode (SCRUB after reset when scrub is built in, RUN otherwise)
//   MAX_REQ         : widest requester count the picker supports
//   rr_onehot()     : rotated-priority one-hot grant
//
// Optional feature macro used by the slice: SDQ_ARB_SCRUB_EN.
package sdq_arb_pkg;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } sdq_arb_state_e;

    localparam int MAX_REQ = 8;

    // First set bit of valid[n-1:0], searching upward from ptr and wrapping
    // at n. The ptr < n precondition keeps ptr+k below 2n, so a single
    // conditional subtract replaces a modulo.
    function automatic logic [MAX_REQ-1:0] rr_onehot(
        input logic [MAX_REQ-1:0] valid,
        input int                 n,
        input int                 ptr
    );
        logic [MAX_REQ-1:0] oh;
        logic               found;
        int                 idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && valid[idx]) begin
                    oh[idx] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/sdq_arbiter_rr_pick.sv
// sdq_rr_pick - combinational round-robin picker.
//
// Ports:
//   req_valid [NUM_REQ]  in  : request present per requester
//   ptr       [PTR_W]    in  : requester with highest priority this cycle
//   grant     [NUM_REQ]  out : one-hot grant, zero when nothing is valid
//   winner    [PTR_W]    out : index of the granted requester (0 when none)
//   any                  out : a grant is issued
module sdq_rr_pick
    import sdq_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               any
);

    always_comb begin
        grant  = NUM_REQ'(rr_onehot(MAX_REQ'(req_valid), NUM_REQ, int'(ptr)));
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                winner = PTR_W'(i);
            end
        end
        any = |grant;
    end

endmodule

// File: rtl/sdq_arbiter.sv
// sdq_arbiter - round-robin sharing of one single-port sdq fakeram macro.
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/ready/we [N]     : per-requester request handshake (ready is one-hot or zero)
//   req_addr  [N*ADDR_WIDTH]   : packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata [N*BITS]         : packed write data, same slicing
//   rsp_valid [N]              : response strobe, one cycle after the grant
//   rsp_rdata [BITS]           : sram_rd passed through, qualified by rsp_valid
//   rsp_err                    : responding request had an out-of-range address
//   busy                       : post-reset scrub in progress
//   sram_ce/we/addr/wd, sram_rd: fakeram port
//
// Build option: define SDQ_ARB_SCRUB_EN to zero-fill the array after every
// reset before requests are accepted. Without it the block resets into RUN.
//
// state | meaning
// SCRUB | writing zero to address scrub_cnt_q, requests held off
// RUN   | normal round-robin arbitration
module sdq_arbiter
    import sdq_arb_pkg::*;
#(
    parameter int BITS       = 16,
    parameter int WORD_DEPTH = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*BITS-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [BITS-1:0]              rsp_rdata,
    output logic                         rsp_err,
    output logic                         busy,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic [ADDR_WIDTH-1:0]        sram_addr,
    output logic [BITS-1:0]              sram_wd,
    input  logic [BITS-1:0]              sram_rd
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    sdq_arb_state_e         state_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       ptr_d;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [PTR_W-1:0]       winner;
    logic                   pick_any;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [BITS-1:0]        win_wdata;
    logic                   win_in_range;
    logic                   grant_fire;

`ifdef SDQ_ARB_SCRUB_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    sdq_arb_state_e        state_d;
    logic [ADDR_WIDTH-1:0] scrub_cnt_q;
    logic [ADDR_WIDTH-1:0] scrub_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        case (state_q)
            SCRUB: begin
                if (scrub_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    scrub_cnt_d = scrub_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == SCRUB);
`else
    assign state_q = RUN;
    assign busy    = 1'b0;
`endif

    sdq_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .winner    (winner),
        .any       (pick_any)
    );

    assign win_addr     = req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_wdata    = req_wdata[winner*BITS +: BITS];
    assign win_in_range = (32'(win_addr) < 32'(WORD_DEPTH));

    // Combinational outputs are gated with rst_n so they read zero while the
    // reset is held, even though req_valid may still be toggling.
    always_comb begin
        req_ready  = '0;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wd    = '0;
        ptr_d      = ptr_q;
        grant_fire = 1'b0;
        if (rst_n) begin
`ifdef SDQ_ARB_SCRUB_EN
            if (state_q == SCRUB) begin
                sram_ce   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = scrub_cnt_q;
                sram_wd   = '0;
            end else
`endif
            if (pick_any && state_q == RUN) begin
                req_ready  = pick_grant;
                grant_fire = 1'b1;
                sram_ce    = 1'b1;
                // Out-of-range accesses still get a slot and a response, but
                // must never alias onto a real word.
                sram_we    = req_we[winner] & win_in_range;
                sram_addr  = win_addr;
                sram_wd    = win_wdata;
                ptr_d      = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_valid <= req_ready;
            rsp_err   <= grant_fire & ~win_in_range;
        end
    end

    assign rsp_rdata = sram_rd;

endmodule
